// File: rtl/mat_uart_pkg.sv
// mat_uart_pkg: shared state encoding and word/byte geometry for the UART matrix path
package mat_uart_pkg;
  typedef enum logic {RECEIVE, HOLD} asm_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int BCNT_W = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/uart_byte_packer.sv
// uart_byte_packer: packs little-endian bytes into 32-bit words; ports: clk, rst, rx_byte/rx_valid in, enable, flush, word/word_valid/byte_cnt out
module uart_byte_packer
  import mat_uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_valid,
  input  logic              enable,
  input  logic              flush,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [BCNT_W-1:0] byte_cnt
);
  logic [WORD_W-BYTE_W-1:0] sr;
  logic accept;
  assign accept = rx_valid && enable;
  // Bytes enter at the top so after three bytes sr = {b2, b1, b0}
  assign word = {rx_byte, sr};
  assign word_valid = accept && byte_cnt == BCNT_W'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      byte_cnt <= '0;
    end else if (flush) begin
      byte_cnt <= '0;
    end else if (accept) begin
      sr <= {rx_byte, sr[WORD_W-BYTE_W-1:BYTE_W]};
      byte_cnt <= byte_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_mat_assembler.sv
// uart_mat_assembler: fills a row-major word matrix from UART bytes and hands it to the serializer; ports: clk, rst, rx_byte/rx_valid, send_done in; matrix, matrix_valid, frame_err, overrun out
module uart_mat_assembler
  import mat_uart_pkg::*;
#(
  parameter int NUM_OF_ROWS = 16,
  parameter int NUM_OF_COLS = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [BYTE_W-1:0]                              rx_byte,
  input  logic                                           rx_valid,
  input  logic                                           send_done,
  output logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][WORD_W-1:0] matrix,
  output logic                                           matrix_valid,
  output logic                                           frame_err,
  output logic                                           overrun
);
  localparam int RW = NUM_OF_ROWS > 1 ? $clog2(NUM_OF_ROWS) : 1;
  localparam int CW = NUM_OF_COLS > 1 ? $clog2(NUM_OF_COLS) : 1;
  localparam int IW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_OF_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_OF_COLS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  asm_state_t state, state_n;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [IW-1:0] idle_cnt;
  logic [WORD_W-1:0] word;
  logic [BCNT_W-1:0] byte_cnt;
  logic word_valid, partial, timeout, last_word, col_last;
  uart_byte_packer u_packer (
    .clk(clk),
    .rst(rst),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .enable(state == RECEIVE),
    .flush(timeout),
    .word(word),
    .word_valid(word_valid),
    .byte_cnt(byte_cnt)
  );
  assign partial = byte_cnt != '0 || row != '0 || col != '0;
  // A byte on the would-be timeout edge wins: rx_valid suppresses the flush
  assign timeout = partial && !rx_valid && idle_cnt == IDLE_LAST;
  assign col_last = col == COL_LAST;
  assign last_word = word_valid && row == ROW_LAST && col_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RECEIVE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == RECEIVE) ? (last_word ? HOLD : RECEIVE) : (send_done ? RECEIVE : HOLD);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row <= '0;
      col <= '0;
      idle_cnt <= '0;
      matrix <= '0;
      matrix_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (timeout || last_word) begin
        row <= '0;
        col <= '0;
      end else if (word_valid) begin
        col <= col_last ? '0 : col + 1'b1;
        row <= col_last ? row + 1'b1 : row;
      end
      idle_cnt <= (!partial || rx_valid || timeout) ? '0 : idle_cnt + 1'b1;
      if (word_valid) matrix[row][col] <= word;
      matrix_valid <= last_word;
      frame_err <= timeout;
      overrun <= overrun || (state == HOLD && rx_valid);
    end
endmodule

// File: tb/tb_uart_mat_assembler.sv
// tb_uart_mat_assembler: randomized scoreboard bench for uart_mat_assembler
module tb_uart_mat_assembler;
  localparam int R = 16;
  localparam int C = 16;
  localparam int T = 10;
  localparam int NB = R * C * 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_byte = '0;
  logic rx_valid = 1'b0;
  logic send_done = 1'b0;
  logic [R-1:0][C-1:0][31:0] matrix;
  logic matrix_valid, frame_err, overrun;
  uart_mat_assembler #(.NUM_OF_ROWS(R), .NUM_OF_COLS(C), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .send_done(send_done),
    .matrix(matrix),
    .matrix_valid(matrix_valid),
    .frame_err(frame_err),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0, ecount = 0;
  bit mon_en = 1'b0;
  logic [7:0] pend[$];
  int idle = 0;
  bit m_hold = 1'b0, m_ovr = 1'b0;
  logic [31:0] exp_mat[R][C];
  int mv_q[$], err_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, ecount);
    end
  endtask
  function automatic int first_diff();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (matrix[r][c] !== exp_mat[r][c]) return r * C + c;
    return -1;
  endfunction
  function automatic int nonzero_words();
    int n = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (matrix[r][c] !== 32'h0) n++;
    return n;
  endfunction
  // One clock edge of stimulus; the reference model advances on the same edge
  task automatic step(input logic v, input logic [7:0] b, input logic sd);
    rx_valid = v;
    rx_byte = b;
    send_done = sd;
    @(posedge clk);
    ecount++;
    if (m_hold) begin
      if (v) m_ovr = 1'b1;
      if (sd) m_hold = 1'b0;
    end else if (v) begin
      pend.push_back(b);
      idle = 0;
      if (pend.size() == NB) begin
        for (int k = 0; k < R * C; k++)
          exp_mat[k / C][k % C] = {pend[4*k+3], pend[4*k+2], pend[4*k+1], pend[4*k]};
        mv_q.push_back(ecount);
        m_hold = 1'b1;
        pend.delete();
      end
    end else if (pend.size() != 0) begin
      idle++;
      if (idle == T) begin
        err_q.push_back(ecount);
        pend.delete();
        idle = 0;
      end
    end
    #1;
    rx_valid = 1'b0;
    send_done = 1'b0;
  endtask
  task automatic send_frame(input int mode);
    for (int i = 0; i < NB; i++)
      step(1'b1, mode == 0 ? 8'(i) : mode == 1 ? 8'hA5 : 8'($urandom), 1'b0);
  endtask
  always @(negedge clk) begin : monitor
    int c;
    if (mon_en) begin
      check("overrun", overrun, m_ovr);
      if (matrix_valid) begin
        if (mv_q.size() == 0) check("matrix_valid unexpected", 1, 0);
        else begin
          c = mv_q.pop_front();
          check("matrix_valid edge", ecount, c);
          check("matrix frame first bad word", first_diff(), -1);
        end
      end else if (mv_q.size() != 0 && mv_q[0] < ecount) begin
        void'(mv_q.pop_front());
        check("matrix_valid missing", 0, 1);
      end
      if (frame_err) begin
        if (err_q.size() == 0) check("frame_err unexpected", 1, 0);
        else begin
          c = err_q.pop_front();
          check("frame_err edge", ecount, c);
        end
      end else if (err_q.size() != 0 && err_q[0] < ecount) begin
        void'(err_q.pop_front());
        check("frame_err missing", 0, 1);
      end
      if (m_hold && !matrix_valid) check("held matrix first bad word", first_diff(), -1);
    end
  end
  initial begin
    logic [7:0] b[4];
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) exp_mat[r][c] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset matrix_valid", matrix_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    check("reset matrix nonzero words", nonzero_words(), 0);
    mon_en = 1'b1;
    // Full frame of incrementing bytes
    send_frame(0);
    step(1'b0, 8'h0, 1'b0);
    check("full m[0][0]", matrix[0][0], 32'h03020100);
    check("full m[15][15]", matrix[15][15], 32'hFFFEFDFC);
    // Handoff to a second frame of 0xA5
    repeat (49) step(1'b0, 8'h0, 1'b0);
    step(1'b0, 8'h0, 1'b1);
    send_frame(1);
    step(1'b0, 8'h0, 1'b0);
    check("handoff m[7][3]", matrix[7][3], 32'hA5A5A5A5);
    // Overrun during HOLD, including a byte coinciding with send_done
    repeat (3) step(1'b1, 8'($urandom), 1'b0);
    check("overrun set", overrun, 1);
    repeat (5) step(1'b0, 8'h0, 1'b0);
    step(1'b1, 8'($urandom), 1'b1);
    send_frame(2);
    step(1'b0, 8'h0, 1'b0);
    check("overrun sticky", overrun, 1);
    // Timeout after a 6-byte partial frame
    step(1'b0, 8'h0, 1'b1);
    repeat (6) step(1'b1, 8'($urandom), 1'b0);
    repeat (15) step(1'b0, 8'h0, 1'b0);
    send_frame(2);
    step(1'b0, 8'h0, 1'b0);
    // Byte lands on the exact timeout edge
    step(1'b0, 8'h0, 1'b1);
    repeat (6) step(1'b1, 8'($urandom), 1'b0);
    repeat (T - 1) step(1'b0, 8'h0, 1'b0);
    for (int i = 6; i < NB; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h0, 1'b0);
    // Randomized traffic with gaps, occasional long stalls and random handoffs
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 600) == 0) repeat ($urandom_range(T - 2, T + 2)) step(1'b0, 8'h0, 1'b0);
      step($urandom_range(0, 3) != 0, 8'($urandom), m_hold && $urandom_range(0, 7) == 0);
    end
    // Asynchronous reset mid-word, between clock edges
    if (m_hold) step(1'b0, 8'h0, 1'b1);
    repeat (2) step(1'b1, 8'($urandom), 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async rst matrix_valid", matrix_valid, 0);
    check("async rst frame_err", frame_err, 0);
    check("async rst overrun", overrun, 0);
    check("async rst matrix nonzero words", nonzero_words(), 0);
    pend.delete();
    idle = 0;
    m_hold = 1'b0;
    m_ovr = 1'b0;
    mv_q.delete();
    err_q.delete();
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      step(1'b1, b[i], 1'b0);
    end
    check("post-reset m[0][0]", matrix[0][0], {b[3], b[2], b[1], b[0]});
    check("post-reset m[0][1]", matrix[0][1], 32'h0);
    repeat (T + 2) step(1'b0, 8'h0, 1'b0);
    check("unserved expected events", mv_q.size() + err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
